// File: rtl/tl_pkg.sv
// TileLink-UL opcode constants, front-end FSM states and the
// lg2-size to beat-count helper shared by the flash front-end.
package tl_pkg;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_FWD,
    ST_DRAIN,
    ST_ERR
  } fe_state_e;

  // 32-bit bus: anything up to a word is one beat.
  function automatic logic [15:0] beats_of(
    input logic [3:0] size
  );
    if (size <= 4'd2) return 16'd1;
    return 16'd1 << (size - 4'd2);
  endfunction

endpackage

// File: rtl/tl_flash_frontend.sv
// TileLink-UL slave front-end for the SPI flash read controller.
// Ports: host A/D channels (a_*, d_*), controller A (flash_a_*) and D (flash_d_*).
module tl_flash_frontend
  import tl_pkg::*;
#(
  parameter int         TL_RS    = 3,
  parameter logic [7:0] BASE_HI  = 8'h20,
  parameter int         MAX_SIZE = 6
) (
  input  logic             flash_clock_i,
  input  logic             flash_reset_i,
  input  logic [2:0]       a_opcode,
  input  logic [2:0]       a_param,
  input  logic [3:0]       a_size,
  input  logic [TL_RS-1:0] a_source,
  input  logic [31:0]      a_address,
  input  logic [3:0]       a_mask,
  input  logic [31:0]      a_data,
  input  logic             a_valid,
  output logic             a_ready,
  output logic [2:0]       d_opcode,
  output logic [3:0]       d_size,
  output logic [TL_RS-1:0] d_source,
  output logic             d_denied,
  output logic [31:0]      d_data,
  output logic             d_corrupt,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [3:0]       flash_a_size,
  output logic [TL_RS-1:0] flash_a_source,
  output logic [23:0]      flash_a_address,
  output logic             flash_a_valid,
  input  logic             flash_a_ready,
  input  logic [2:0]       flash_d_opcode,
  input  logic [3:0]       flash_d_size,
  input  logic [TL_RS-1:0] flash_d_source,
  input  logic             flash_d_denied,
  input  logic [31:0]      flash_d_data,
  input  logic             flash_d_corrupt,
  input  logic             flash_d_valid,
  output logic             flash_d_ready
);

  localparam int CW =
    (MAX_SIZE - 1 < 1) ? 1 : MAX_SIZE - 1;
  localparam logic [3:0] MAX_SZ = 4'(MAX_SIZE);

  fe_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]       size_q;
  logic [TL_RS-1:0] src_q;
  logic [23:0]      addr_q;
  logic             get_q;

  logic        is_get;
  logic        is_put;
  logic        aligned;
  logic        legal;
  logic [15:0] a_beats;
  logic [31:0] amask;

  logic unused_ok;
  assign unused_ok = ^{a_param, a_mask, a_data};

  assign is_get  = a_opcode == OP_GET;
  assign is_put  = a_opcode == OP_PUT_FULL
                || a_opcode == OP_PUT_PART;
  assign a_beats = beats_of(a_size);
  assign amask   = (32'd1 << a_size) - 32'd1;
  assign aligned = (a_address & amask) == 32'd0;
  assign legal   = is_get
                && a_size <= MAX_SZ
                && a_address[31:24] == BASE_HI
                && aligned;

  always_ff @(posedge flash_clock_i or negedge flash_reset_i) begin
    if (!flash_reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge flash_clock_i or negedge flash_reset_i) begin
    if (!flash_reset_i) begin
      size_q <= '0;
      src_q  <= '0;
      addr_q <= '0;
      get_q  <= 1'b0;
    end else if (state_q == ST_IDLE && a_valid) begin
      size_q <= a_size;
      src_q  <= a_source;
      addr_q <= a_address[23:0];
      get_q  <= is_get;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    a_ready         = 1'b0;
    d_valid         = 1'b0;
    d_opcode        = '0;
    d_size          = '0;
    d_source        = '0;
    d_denied        = 1'b0;
    d_data          = '0;
    d_corrupt       = 1'b0;
    flash_a_valid   = 1'b0;
    flash_a_size    = '0;
    flash_a_source  = '0;
    flash_a_address = '0;
    flash_d_ready   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        a_ready = 1'b1;
        if (a_valid) begin
          if (legal) begin
            state_d = ST_ISSUE;
          end else if (is_put && a_beats > 16'd1) begin
            state_d = ST_DRAIN;
            cnt_d   = CW'(a_beats - 16'd1);
          end else begin
            state_d = ST_ERR;
            cnt_d   = is_get ? CW'(a_beats - 16'd1) : '0;
          end
        end
      end
      ST_ISSUE: begin
        flash_a_valid   = 1'b1;
        flash_a_size    = size_q;
        flash_a_source  = src_q;
        flash_a_address = addr_q;
        if (flash_a_ready) begin
          state_d = ST_FWD;
          cnt_d   = CW'(beats_of(size_q) - 16'd1);
        end
      end
      ST_FWD: begin
        d_valid       = flash_d_valid;
        flash_d_ready = d_ready;
        d_opcode      = flash_d_opcode;
        d_size        = flash_d_size;
        d_source      = flash_d_source;
        d_denied      = flash_d_denied;
        d_data        = flash_d_data;
        d_corrupt     = flash_d_corrupt;
        if (flash_d_valid && d_ready) begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        a_ready = 1'b1;
        // Counter holds beats still owed; the beat taken at 1 is the last.
        if (a_valid) begin
          if (cnt_q <= CW'(1)) begin
            state_d = ST_ERR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_ERR: begin
        d_valid   = 1'b1;
        d_denied  = 1'b1;
        d_source  = src_q;
        d_size    = size_q;
        d_opcode  = get_q ? OP_ACK_DATA : OP_ACK;
        d_corrupt = get_q;
        if (d_ready) begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
